// File: rtl/camera_frame_capture.sv
// camera_frame_capture
//   Capture engine between a parallel-output image sensor (PCLK/VSYNC/HREF/D)
//   and a single-port frame RAM. Generates the sensor master clock, brings the
//   sensor bus into the i_Clk domain, assembles multi-byte pixels, optionally
//   decimates in X and Y, and writes one pixel word per strobe to sequential
//   RAM addresses. Frames are captured single-shot or continuously.
//
// Ports
//   i_Clk               system clock, all logic on rising edge
//   i_Reset_n           synchronous active-low reset
//   i_PLK               sensor pixel clock (asynchronous)
//   i_VS                sensor VSYNC, high = vertical blanking
//   i_HS                sensor HREF, high = valid line data
//   i_D                 sensor data
//   i_Start             one-cycle pulse, arms one capture
//   i_Continuous        level, capture every frame while high
//   o_XLK               sensor master clock, period 2*XCLK_DIV
//   o_to_RAM            pixel word, first byte in MSBs
//   o_RAM_Adress        write address
//   o_RAM_Write_Enable  one-cycle write strobe
//   o_Busy              high outside IDLE
//   o_Frame_Done        one-cycle pulse at frame end
//   o_Frame_Error       size error of last frame, held until next frame start
//   o_Line_Count        HREF lines seen in current/last frame (saturating)

module camera_frame_capture #(
  parameter int unsigned XCLK_DIV        = 5,
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned BYTES_PER_PIXEL = 2,
  parameter int unsigned ADDR_W          = 15,
  parameter int unsigned FRAME_PIXELS    = 9216,
  parameter int unsigned DECIM           = 1,
  parameter int unsigned LINE_W          = 10
) (
  input  logic                              i_Clk,
  input  logic                              i_Reset_n,
  input  logic                              i_PLK,
  input  logic                              i_VS,
  input  logic                              i_HS,
  input  logic [DATA_W-1:0]                 i_D,
  input  logic                              i_Start,
  input  logic                              i_Continuous,
  output logic                              o_XLK,
  output logic [DATA_W*BYTES_PER_PIXEL-1:0] o_to_RAM,
  output logic [ADDR_W-1:0]                 o_RAM_Adress,
  output logic                              o_RAM_Write_Enable,
  output logic                              o_Busy,
  output logic                              o_Frame_Done,
  output logic                              o_Frame_Error,
  output logic [LINE_W-1:0]                 o_Line_Count
);

  localparam int unsigned PIX_W  = DATA_W * BYTES_PER_PIXEL;
  localparam int unsigned XDIV_W = $clog2(XCLK_DIV) + 1;
  localparam int unsigned PH_W   = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
  localparam int unsigned DEC_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  // One extra bit so FRAME_PIXELS == 2**ADDR_W is still representable.
  localparam int unsigned CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_VS,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  state_t state, state_next;

  // ---------------------------------------------------------------------------
  // Sensor master clock
  // ---------------------------------------------------------------------------
  logic [XDIV_W-1:0] xdiv_cnt;

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      xdiv_cnt <= '0;
      o_XLK    <= 1'b0;
    end else if (xdiv_cnt == XDIV_W'(XCLK_DIV - 1)) begin
      xdiv_cnt <= '0;
      o_XLK    <= ~o_XLK;
    end else begin
      xdiv_cnt <= xdiv_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Synchronisers: bit0 = q1, bit1 = q2, bit2 = q3 (edge-detect stage)
  // ---------------------------------------------------------------------------
  logic [2:0]        plk_sync;
  logic [2:0]        vs_sync;
  logic [2:0]        hs_sync;
  logic [DATA_W-1:0] d_q1;
  logic [DATA_W-1:0] d_q2;

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      plk_sync <= '0;
      vs_sync  <= '0;
      hs_sync  <= '0;
      d_q1     <= '0;
      d_q2     <= '0;
    end else begin
      plk_sync <= {plk_sync[1:0], i_PLK};
      vs_sync  <= {vs_sync[1:0], i_VS};
      hs_sync  <= {hs_sync[1:0], i_HS};
      d_q1     <= i_D;
      d_q2     <= d_q1;
    end
  end

  logic plk_rise;
  logic vs_rise;
  logic vs_fall;
  logic hs_fall;
  logic vs_level;
  logic hs_level;

  assign plk_rise = plk_sync[1] & ~plk_sync[2];
  assign vs_rise  = vs_sync[1]  & ~vs_sync[2];
  assign vs_fall  = ~vs_sync[1] & vs_sync[2];
  assign hs_fall  = ~hs_sync[1] & hs_sync[2];
  assign vs_level = vs_sync[1];
  assign hs_level = hs_sync[1];

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    o_Busy       = 1'b1;
    o_Frame_Done = 1'b0;
    case (state)
      ST_IDLE: begin
        o_Busy = 1'b0;
        if (i_Start || i_Continuous) begin
          state_next = ST_WAIT_VS;
        end
      end
      ST_WAIT_VS: begin
        if (vs_fall) begin
          state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (vs_rise) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        o_Frame_Done = 1'b1;
        state_next   = i_Continuous ? ST_WAIT_VS : ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pixel assembly, decimation and RAM write
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] addr;
  logic [PH_W-1:0]  phase;
  logic [DEC_W-1:0] x_cnt;
  logic [DEC_W-1:0] y_cnt;
  logic [PIX_W-1:0] pix_reg;
  logic [PIX_W-1:0] pix_next;
  logic [DEC_W-1:0] x_inc;
  logic [DEC_W-1:0] y_inc;
  logic             byte_take;
  logic             pix_done;
  logic             pix_keep;
  logic             frame_full;

  // A VS rise forces vs_level high, so a coincident PLK rise is never taken.
  assign byte_take  = (state == ST_CAPTURE) && plk_rise && !vs_level && hs_level;
  assign pix_done   = byte_take && (phase == PH_W'(BYTES_PER_PIXEL - 1));
  assign pix_keep   = pix_done && (x_cnt == '0) && (y_cnt == '0);
  assign frame_full = (addr == CNT_W'(FRAME_PIXELS));
  assign pix_next   = (pix_reg << DATA_W) | PIX_W'(d_q2);
  assign x_inc      = (x_cnt == DEC_W'(DECIM - 1)) ? '0 : x_cnt + 1'b1;
  assign y_inc      = (y_cnt == DEC_W'(DECIM - 1)) ? '0 : y_cnt + 1'b1;

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      addr               <= '0;
      phase              <= '0;
      x_cnt              <= '0;
      y_cnt              <= '0;
      pix_reg            <= '0;
      o_to_RAM           <= '0;
      o_RAM_Adress       <= '0;
      o_RAM_Write_Enable <= 1'b0;
      o_Frame_Error      <= 1'b0;
      o_Line_Count       <= '0;
    end else begin
      o_RAM_Write_Enable <= 1'b0;
      if (state == ST_WAIT_VS && vs_fall) begin
        addr          <= '0;
        phase         <= '0;
        x_cnt         <= '0;
        y_cnt         <= '0;
        o_Line_Count  <= '0;
        o_Frame_Error <= 1'b0;
      end else if (state == ST_CAPTURE) begin
        if (vs_rise) begin
          // Overflow may already have flagged the error; keep it sticky.
          if (!frame_full) begin
            o_Frame_Error <= 1'b1;
          end
        end else if (hs_fall) begin
          if (o_Line_Count != '1) begin
            o_Line_Count <= o_Line_Count + 1'b1;
          end
          phase <= '0;
          x_cnt <= '0;
          y_cnt <= y_inc;
        end else if (byte_take) begin
          pix_reg <= pix_next;
          if (pix_done) begin
            phase <= '0;
            x_cnt <= x_inc;
            if (pix_keep) begin
              if (frame_full) begin
                o_Frame_Error <= 1'b1;
              end else begin
                o_RAM_Write_Enable <= 1'b1;
                o_RAM_Adress       <= addr[ADDR_W-1:0];
                o_to_RAM           <= pix_next;
                addr               <= addr + 1'b1;
              end
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_camera_frame_capture.sv
// Directed bench for camera_frame_capture: reset, master clock, single-shot,
// short/long frames, X/Y decimation, continuous mode and mid-frame reset.
module tb_camera_frame_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        plk = 1'b0;
  logic        vs = 1'b0;
  logic        hs = 1'b0;
  logic [7:0]  d = '0;
  logic        start = 1'b0;
  logic        start_d = 1'b0;
  logic        cont = 1'b0;

  logic        xlk, xlk_d;
  logic [15:0] to_ram, to_ram_d;
  logic [14:0] ram_addr, ram_addr_d;
  logic        we, we_d;
  logic        busy, busy_d;
  logic        done, done_d;
  logic        ferr, ferr_d;
  logic [9:0]  lines, lines_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  camera_frame_capture #(
    .XCLK_DIV(5), .DATA_W(8), .BYTES_PER_PIXEL(2), .ADDR_W(15),
    .FRAME_PIXELS(12), .DECIM(1), .LINE_W(10)
  ) dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_PLK(plk), .i_VS(vs), .i_HS(hs), .i_D(d),
    .i_Start(start), .i_Continuous(cont), .o_XLK(xlk), .o_to_RAM(to_ram),
    .o_RAM_Adress(ram_addr), .o_RAM_Write_Enable(we), .o_Busy(busy),
    .o_Frame_Done(done), .o_Frame_Error(ferr), .o_Line_Count(lines)
  );

  camera_frame_capture #(
    .XCLK_DIV(5), .DATA_W(8), .BYTES_PER_PIXEL(2), .ADDR_W(15),
    .FRAME_PIXELS(4), .DECIM(2), .LINE_W(10)
  ) dut_d (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_PLK(plk), .i_VS(vs), .i_HS(hs), .i_D(d),
    .i_Start(start_d), .i_Continuous(1'b0), .o_XLK(xlk_d), .o_to_RAM(to_ram_d),
    .o_RAM_Adress(ram_addr_d), .o_RAM_Write_Enable(we_d), .o_Busy(busy_d),
    .o_Frame_Done(done_d), .o_Frame_Error(ferr_d), .o_Line_Count(lines_d)
  );

  // Write / done loggers
  logic [15:0] wr_data [64];
  logic [14:0] wr_addr [64];
  int          wr_n = 0;
  int          done_n = 0;
  logic        done_err = 1'b0;
  logic [15:0] wr_data_d [8];
  logic [14:0] wr_addr_d [8];
  int          wr_n_d = 0;
  int          done_n_d = 0;
  logic        done_err_d = 1'b0;

  always @(negedge clk) begin
    if (we) begin
      if (wr_n < 64) begin
        wr_data[wr_n] = to_ram;
        wr_addr[wr_n] = ram_addr;
      end
      wr_n = wr_n + 1;
    end
    if (done) begin
      done_n   = done_n + 1;
      done_err = ferr;
    end
    if (we_d) begin
      if (wr_n_d < 8) begin
        wr_data_d[wr_n_d] = to_ram_d;
        wr_addr_d[wr_n_d] = ram_addr_d;
      end
      wr_n_d = wr_n_d + 1;
    end
    if (done_d) begin
      done_n_d   = done_n_d + 1;
      done_err_d = ferr_d;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sensor byte stream: 0x12, 0x34, 0x56, ... (step 0x22, mod 256)
  int bn = 0;
  function automatic logic [7:0] bval(input int n);
    int v;
    v = 'h12 + 'h22 * n;
    return v[7:0];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    d = b;
    tick(3);
    plk = 1'b1;
    tick(3);
    plk = 1'b0;
  endtask

  task automatic send_line(input int npix);
    hs = 1'b1;
    tick(2);
    for (int i = 0; i < npix * 2; i++) begin
      send_byte(bval(bn));
      bn++;
    end
    tick(2);
    hs = 1'b0;
    tick(4);
  endtask

  task automatic start_frame();
    bn = 0;
    vs = 1'b1;
    tick(6);
    vs = 1'b0;
    tick(4);
  endtask

  task automatic end_frame();
    vs = 1'b1;
    tick(8);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic clear_logs();
    wr_n = 0; done_n = 0; done_err = 1'b0;
    wr_n_d = 0; done_n_d = 0; done_err_d = 1'b0;
  endtask

  function automatic logic [63:0] all_outs();
    return {18'd0, xlk, busy, done, ferr, we, to_ram, ram_addr, lines};
  endfunction

  initial begin
    int  cyc;
    bit  found;
    logic prev;

    // ---- Reset with toggling inputs
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      plk = i[0]; vs = ~i[0]; hs = i[1]; d = 8'(i * 'h11 + 5);
      start = 1'b1; cont = i[0];
      tick(1);
      chk("reset_outputs_zero", all_outs(), 64'd0);
    end
    plk = 0; vs = 0; hs = 0; d = 0; start = 0; cont = 0;
    tick(1);
    rst_n = 1'b1;

    // ---- Master clock period: find a rising edge, then time the next one
    found = 0; prev = xlk;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1);
      if (xlk && !prev) found = 1;
      prev = xlk;
    end
    chk("xlk_first_rise_seen", 64'(found), 64'd1);
    found = 0; cyc = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1);
      cyc++;
      if (xlk && !prev) found = 1;
      prev = xlk;
    end
    chk("xlk_period", 64'(cyc), 64'd10);

    // ---- Single-shot, 3 lines x 4 pixels
    clear_logs();
    vs = 1'b1;
    tick(2);
    pulse_start();
    chk("busy_after_start", 64'(busy), 64'd1);
    start_frame();
    for (int l = 0; l < 3; l++) send_line(4);
    end_frame();
    chk("single_write_count", 64'(wr_n), 64'd12);
    for (int i = 0; i < 12; i++) chk("single_addr_seq", 64'(wr_addr[i]), 64'(i));
    chk("single_data0", 64'(wr_data[0]), 64'h1234);
    chk("single_data1", 64'(wr_data[1]), 64'h5678);
    chk("single_data3", 64'(wr_data[3]), 64'hDE00);
    chk("single_data11", 64'(wr_data[11]), 64'hFE20);
    chk("single_done_count", 64'(done_n), 64'd1);
    chk("single_err_at_done", 64'(done_err), 64'd0);
    chk("single_line_count", 64'(lines), 64'd3);
    chk("single_idle_after", 64'(busy), 64'd0);

    // ---- Short frame: 2 lines x 5 = 10 pixels
    clear_logs();
    pulse_start();
    start_frame();
    for (int l = 0; l < 2; l++) send_line(5);
    end_frame();
    chk("short_write_count", 64'(wr_n), 64'd10);
    chk("short_done_count", 64'(done_n), 64'd1);
    chk("short_err_at_done", 64'(done_err), 64'd1);
    chk("short_err_held", 64'(ferr), 64'd1);

    // ---- Long frame: 2 lines x 7 = 14 pixels
    clear_logs();
    pulse_start();
    start_frame();
    send_line(7);
    chk("long_err_cleared_line1", 64'(ferr), 64'd0);
    send_line(7);
    chk("long_err_on_overflow", 64'(ferr), 64'd1);
    chk("long_done_not_yet", 64'(done_n), 64'd0);
    end_frame();
    chk("long_write_count", 64'(wr_n), 64'd12);
    chk("long_last_addr", 64'(wr_addr[11]), 64'd11);
    chk("long_done_count", 64'(done_n), 64'd1);
    chk("long_err_at_done", 64'(done_err), 64'd1);
    chk("long_line_count", 64'(lines), 64'd2);

    // ---- Decimation by 2 on a 4x4 frame
    clear_logs();
    start_d = 1'b1;
    tick(1);
    start_d = 1'b0;
    start_frame();
    for (int l = 0; l < 4; l++) send_line(4);
    end_frame();
    chk("decim_write_count", 64'(wr_n_d), 64'd4);
    for (int i = 0; i < 4; i++) chk("decim_addr_seq", 64'(wr_addr_d[i]), 64'(i));
    chk("decim_pix_0_0", 64'(wr_data_d[0]), 64'h1234);
    chk("decim_pix_0_2", 64'(wr_data_d[1]), 64'h9ABC);
    chk("decim_pix_2_0", 64'(wr_data_d[2]), 64'h3254);
    chk("decim_pix_2_2", 64'(wr_data_d[3]), 64'hBADC);
    chk("decim_done_count", 64'(done_n_d), 64'd1);
    chk("decim_err_at_done", 64'(done_err_d), 64'd0);
    chk("decim_line_count", 64'(lines_d), 64'd4);
    chk("decim_main_untouched", 64'(wr_n), 64'd0);

    // ---- Continuous mode, 3 frames; i_Start mid-frame; drop level in frame 3
    clear_logs();
    cont = 1'b1;
    tick(2);
    start_frame();
    send_line(4);
    pulse_start();
    send_line(4);
    send_line(4);
    end_frame();
    chk("cont_busy_between", 64'(busy), 64'd1);
    start_frame();
    for (int l = 0; l < 3; l++) send_line(4);
    end_frame();
    start_frame();
    send_line(4);
    cont = 1'b0;
    send_line(4);
    send_line(4);
    end_frame();
    chk("cont_done_count", 64'(done_n), 64'd3);
    chk("cont_write_count", 64'(wr_n), 64'd36);
    chk("cont_f1_addr0", 64'(wr_addr[0]), 64'd0);
    chk("cont_f2_addr0", 64'(wr_addr[12]), 64'd0);
    chk("cont_f3_addr0", 64'(wr_addr[24]), 64'd0);
    chk("cont_f3_last", 64'(wr_addr[35]), 64'd11);
    chk("cont_idle_after", 64'(busy), 64'd0);

    // ---- Reset in the middle of line 2
    clear_logs();
    pulse_start();
    start_frame();
    send_line(4);
    hs = 1'b1;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      send_byte(bval(bn));
      bn++;
    end
    rst_n = 1'b0;
    tick(2);
    chk("midreset_outputs_zero", all_outs(), 64'd0);
    rst_n = 1'b1;
    send_byte(bval(bn));
    bn++;
    tick(2);
    hs = 1'b0;
    tick(4);
    send_line(4);
    end_frame();
    chk("midreset_no_done", 64'(done_n), 64'd0);
    chk("midreset_writes_before", 64'(wr_n), 64'd5);
    pulse_start();
    start_frame();
    for (int l = 0; l < 3; l++) send_line(4);
    end_frame();
    chk("recover_write_count", 64'(wr_n), 64'd17);
    chk("recover_first_addr", 64'(wr_addr[5]), 64'd0);
    chk("recover_first_data", 64'(wr_data[5]), 64'h1234);
    chk("recover_done_count", 64'(done_n), 64'd1);
    chk("recover_err_at_done", 64'(done_err), 64'd0);
    chk("recover_line_count", 64'(lines), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/camera_frame_capture.md
# camera_frame_capture

Parametrised camera capture engine between a parallel-output image sensor (OV7670-class: PCLK/VSYNC/HREF/D[7:0]) and a single-port frame RAM. It generates the sensor master clock, synchronises the sensor bus into the system clock domain, assembles multi-byte pixels, and optionally decimates in X/Y. It writes one pixel word per strobe to sequential RAM addresses and reports frame completion and frame-size errors. Frames are captured single-shot on request or continuously.

## Interface
- XCLK_DIV, 5: o_XLK half-period in i_Clk cycles (≥1).
- DATA_W, 8: sensor bus width.
- BYTES_PER_PIXEL, 2: bytes per pixel (1 or 2).
- ADDR_W, 15: RAM address width.
- FRAME_PIXELS, 9216: expected pixels written per frame after decimation (≤2^ADDR_W).
- DECIM, 1: X and Y decimation factor (1, 2 or 4).
- LINE_W, 10: line counter width.

- i_Clk  in  1  system clock; all logic on rising edge.
- i_Reset_n  in  1  synchronous, active-low reset.
- i_PLK  in  1  sensor pixel clock (asynchronous).
- i_VS  in  1  sensor VSYNC; high = vertical blanking.
- i_HS  in  1  sensor HREF; high = valid line data.
- i_D  in  DATA_W  sensor data.
- i_Start  in  1  one-cycle pulse; arms one capture.
- i_Continuous  in  1  level; 1 = capture every frame.
- o_XLK  out  1  sensor master clock.
- o_to_RAM  out  DATA_W*BYTES_PER_PIXEL  pixel word; first byte in MSBs.
- o_RAM_Adress  out  ADDR_W  write address.
- o_RAM_Write_Enable  out  1  one-cycle write strobe.
- o_Busy  out  1  high outside IDLE.
- o_Frame_Done  out  1  one-cycle pulse at frame end.
- o_Frame_Error  out  1  size error for the last frame; held until next frame start.
- o_Line_Count  out  LINE_W  HREF lines seen in current/last frame (saturating).

## Operation
- Reset (i_Reset_n=0 at a clock edge): all outputs 0; state IDLE; o_XLK divider counter 0; synchronisers cleared. Reset mid-frame aborts with no o_Frame_Done.
- o_XLK: free-running outside reset; toggles when divider counter reaches XCLK_DIV-1, then counter wraps to 0. Period 2*XCLK_DIV cycles, 50% duty.
- Synchronisation: i_PLK, i_VS, i_HS, i_D each pass a 2-flop synchroniser. A third stage gives edge detection. PLK rise = q2&~q3. VS rise/fall and HS fall use the same scheme. Data is taken from the D q2 stage, aligned with the PLK rise.
- FSM:
  - IDLE: go to WAIT_VS on i_Start=1 or i_Continuous=1.
  - WAIT_VS: on VS fall, go to CAPTURE. Clear address, byte phase, X/Y decimation counters, o_Line_Count and o_Frame_Error.
  - CAPTURE: on PLK rise with synced VS=0 and HS=1:
    - Shift the byte into the pixel register and advance byte phase.
    - When phase wraps from BYTES_PER_PIXEL-1 to 0, a pixel is complete and the X counter advances (mod DECIM).
    - The pixel is written if the X and Y counters are both 0 at completion.
    - Written pixel occupies the current address; the address then increments.
  - CAPTURE, HS fall: o_Line_Count+1 (saturates at all-ones); byte phase and X counter reset to 0; Y counter advances mod DECIM. A partial pixel at line end is discarded.
  - CAPTURE, VS rise: go to DONE. o_Frame_Error=1 if written count ≠ FRAME_PIXELS.
  - DONE: o_Frame_Done=1 for this cycle only. Next state is WAIT_VS if i_Continuous=1, else IDLE.
- Overflow: a write attempted when the address equals FRAME_PIXELS is suppressed. o_Frame_Error is set immediately. The address does not wrap.
- Simultaneous events: VS rise and PLK rise in the same cycle → VS wins, no write. i_Start while o_Busy=1 is ignored. i_Continuous dropped mid-frame finishes the current frame, then goes to IDLE.
- o_to_RAM and o_RAM_Adress are registered and hold their last values between strobes.

## Timing
- PLK high and low phases each must last ≥2 i_Clk cycles. VS and HS must be stable across the PLK rise.
- Write latency: i_PLK first sampled high at edge k. o_RAM_Write_Enable, o_RAM_Adress and o_to_RAM are valid together in the cycle after edge k+2.
- o_Busy rises the cycle after an accepted i_Start. It falls the cycle after DONE (single-shot).
- o_Frame_Done is asserted 3 cycles after the VS rise reaches the pin-side synchroniser.
- Peak throughput: one write per BYTES_PER_PIXEL PLK periods.

## Test plan
- Reset: hold i_Reset_n=0 while toggling all inputs → all outputs 0, o_XLK static 0. Release → o_XLK period 10 cycles (XCLK_DIV=5).
- Single-shot, BYTES_PER_PIXEL=2, FRAME_PIXELS=12, 3 lines × 4 pixels, bytes 0x12,0x34,… → first write addr 0 data 0x1234; 12 strobes at addr 0..11; one o_Frame_Done; o_Frame_Error=0; o_Line_Count=3; then IDLE.
- DECIM=2 on a 4×4 frame, FRAME_PIXELS=4 → writes only pixels (0,0),(0,2),(2,0),(2,2) at addr 0..3; no error.
- Short frame (10 pixels) → Frame_Done with Frame_Error=1. Long frame (14 pixels) → strobes stop after addr 11, Frame_Error set at the 13th pixel.
- Continuous mode over 3 frames → 3 Done pulses, address restarts at 0 each frame. Assert i_Start mid-frame → no effect.
- i_Reset_n=0 in the middle of line 2 → outputs 0, no Done pulse. The next i_Start captures the following frame cleanly.
